// File: rtl/game_controller_nxn_if.sv
// Move/board bus between a player front-end (master) and game_controller_nxn (slave).
// timeoutPulse exists only when MOVE_TIMEOUT_EN is defined.
interface game_controller_nxn_if #(
    parameter int unsigned BOARD_N = 3,
    parameter int unsigned ADDR_W  = $clog2(BOARD_N * BOARD_N)
);
    logic                           isPlayer1Start;
    logic                           newGame;
    logic                           playerWrite;
    logic [ADDR_W-1:0]              playerInput;
    logic [2*BOARD_N*BOARD_N-1:0]   gBoard;
    logic                           gameIsDone;
    logic [1:0]                     winner;
    logic                           currentPlayer;
    logic                           moveAccepted;
    logic                           moveRejected;
    logic [ADDR_W:0]                moveCount;
`ifdef MOVE_TIMEOUT_EN
    logic                           timeoutPulse;
`endif

    modport master (
        output isPlayer1Start, newGame, playerWrite, playerInput,
        input  gBoard, gameIsDone, winner, currentPlayer, moveAccepted, moveRejected, moveCount
`ifdef MOVE_TIMEOUT_EN
        , input timeoutPulse
`endif
    );

    modport slave (
        input  isPlayer1Start, newGame, playerWrite, playerInput,
        output gBoard, gameIsDone, winner, currentPlayer, moveAccepted, moveRejected, moveCount
`ifdef MOVE_TIMEOUT_EN
        , output timeoutPulse
`endif
    );
endinterface

// File: rtl/game_controller_nxn.sv
// N x N tic-tac-toe controller: owns the board, validates moves, detects wins/draws.
// Optional MOVE_TIMEOUT_EN passes the turn after TIMEOUT_CYCLES idle cycles.
module game_controller_nxn #(
    parameter int unsigned BOARD_N        = 3,
    parameter int unsigned ADDR_W         = $clog2(BOARD_N * BOARD_N),
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                  ph1,
    input  logic                  reset,
    game_controller_nxn_if.slave  bus
);
    localparam int unsigned CELLS = BOARD_N * BOARD_N;
    localparam int unsigned BW    = 2 * CELLS;
    localparam int unsigned CW    = ADDR_W + 1;
    localparam logic [1:0]  EMPTY  = 2'b00;
    localparam logic [1:0]  MARK_X = 2'b10;
    localparam logic [1:0]  MARK_O = 2'b11;

    if (BOARD_N < 3 || BOARD_N > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_param
        $error("game_controller_nxn: BOARD_N must be 3..8 and TIMEOUT_CYCLES nonzero");
    end

    typedef enum logic [1:0] {S_CLEAR, S_PLAYER1, S_PLAYER2, S_END} state_t;

    state_t            r_state, w_next_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [BW-1:0]     r_board;
    logic              r_check;
    logic              r_done, r_cur, r_acc, r_rej;
    logic [1:0]        r_winner;
    logic [CW-1:0]     r_move_cnt;

    logic              w_in_turn, w_in_range, w_legal, w_accept, w_reject;
    logic              w_clear_last, w_win, w_draw, w_game_over, w_timeout;
    logic [ADDR_W-1:0] w_idx;
    logic [1:0]        w_target, w_mark, w_win_code;
    logic [2:0]        w_line;
    logic              w_done_nxt, w_cur_nxt;
    logic [1:0]        w_winner_nxt;
    logic [CW-1:0]     w_cnt_nxt;

    // {all-equal-and-occupied, cell code} for the line starting at 'start' with stride 'step'
    function automatic logic [2:0] f_line(input logic [BW-1:0] b,
                                          input int unsigned start,
                                          input int unsigned step);
        logic [1:0] first;
        logic       same;
        first = b[2*start +: 2];
        same  = (first != EMPTY);
        for (int unsigned k = 1; k < BOARD_N; k++) begin
            if (b[2*(start + k*step) +: 2] != first) same = 1'b0;
        end
        return {same, first};
    endfunction

    always_comb begin
        w_win      = 1'b0;
        w_win_code = EMPTY;
        w_line     = 3'b000;
        for (int unsigned i = 0; i < BOARD_N; i++) begin
            w_line = f_line(r_board, i * BOARD_N, 1);
            if (w_line[2]) begin w_win = 1'b1; w_win_code = w_line[1:0]; end
            w_line = f_line(r_board, i, BOARD_N);
            if (w_line[2]) begin w_win = 1'b1; w_win_code = w_line[1:0]; end
        end
        w_line = f_line(r_board, 0, BOARD_N + 1);
        if (w_line[2]) begin w_win = 1'b1; w_win_code = w_line[1:0]; end
        w_line = f_line(r_board, BOARD_N - 1, BOARD_N - 1);
        if (w_line[2]) begin w_win = 1'b1; w_win_code = w_line[1:0]; end
    end

    assign w_in_turn    = (r_state == S_PLAYER1) || (r_state == S_PLAYER2);
    assign w_in_range   = (32'(bus.playerInput) < CELLS);
    assign w_idx        = w_in_range ? bus.playerInput : '0;
    assign w_target     = r_board[2*int'(w_idx) +: 2];
    assign w_legal      = w_in_range && (w_target == EMPTY);
    assign w_mark       = (r_state == S_PLAYER1) ? MARK_X : MARK_O;
    assign w_clear_last = (32'(r_clr_cnt) == CELLS - 1);
    assign w_draw       = (r_move_cnt == CW'(CELLS));
    // r_check marks the cycle in which the just-placed piece is visible on the board
    assign w_game_over  = w_in_turn && r_check && (w_win || w_draw);
    assign w_accept     = w_in_turn && bus.playerWrite && !bus.newGame && !w_game_over && w_legal;
    assign w_reject     = w_in_turn && bus.playerWrite && !bus.newGame && !w_game_over && !w_legal;

`ifdef MOVE_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_turn_cnt;
    logic          r_timeout;

    assign w_timeout = w_in_turn && !bus.newGame && !w_game_over && !w_accept
                       && (r_turn_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_turn_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_timeout;
            if (!w_in_turn || w_accept || (w_next_state != r_state)) r_turn_cnt <= '0;
            else                                                     r_turn_cnt <= r_turn_cnt + TW'(1);
        end
    end

    assign bus.timeoutPulse = r_timeout;
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) r_state <= S_CLEAR;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (bus.newGame) begin
            w_next_state = S_CLEAR;
        end else begin
            case (r_state)
                S_CLEAR: if (w_clear_last) w_next_state = bus.isPlayer1Start ? S_PLAYER1 : S_PLAYER2;
                S_PLAYER1, S_PLAYER2: begin
                    if (w_game_over)                  w_next_state = S_END;
                    else if (w_accept || w_timeout)   w_next_state = (r_state == S_PLAYER1) ? S_PLAYER2 : S_PLAYER1;
                end
                default: w_next_state = r_state;
            endcase
        end
    end

    always_comb begin
        w_done_nxt   = r_done;
        w_winner_nxt = r_winner;
        w_cnt_nxt    = r_move_cnt;
        w_cur_nxt    = r_cur;
        if (bus.newGame) begin
            w_done_nxt   = 1'b0;
            w_winner_nxt = EMPTY;
            w_cnt_nxt    = '0;
        end else begin
            if (w_game_over) begin
                w_done_nxt   = 1'b1;
                w_winner_nxt = w_win ? w_win_code : EMPTY;
            end
            if (w_accept) w_cnt_nxt = r_move_cnt + CW'(1);
        end
        if (w_next_state == S_PLAYER1)      w_cur_nxt = 1'b0;
        else if (w_next_state == S_PLAYER2) w_cur_nxt = 1'b1;
    end

    // Board storage, sweep-clear counter and registered outputs
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_board    <= '0;
            r_clr_cnt  <= '0;
            r_check    <= 1'b0;
            r_done     <= 1'b0;
            r_winner   <= EMPTY;
            r_cur      <= 1'b0;
            r_acc      <= 1'b0;
            r_rej      <= 1'b0;
            r_move_cnt <= '0;
        end else begin
            r_check    <= w_accept;
            r_acc      <= w_accept;
            r_rej      <= w_reject;
            r_done     <= w_done_nxt;
            r_winner   <= w_winner_nxt;
            r_cur      <= w_cur_nxt;
            r_move_cnt <= w_cnt_nxt;
            if (bus.newGame || r_state != S_CLEAR || w_clear_last) r_clr_cnt <= '0;
            else                                                   r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
            if (r_state == S_CLEAR && !bus.newGame) r_board[2*int'(r_clr_cnt) +: 2] <= EMPTY;
            else if (w_accept)                      r_board[2*int'(w_idx) +: 2]     <= w_mark;
        end
    end

    assign bus.gBoard        = r_board;
    assign bus.gameIsDone    = r_done;
    assign bus.winner        = r_winner;
    assign bus.currentPlayer = r_cur;
    assign bus.moveAccepted  = r_acc;
    assign bus.moveRejected  = r_rej;
    assign bus.moveCount     = r_move_cnt;
endmodule

// File: doc/game_controller_nxn.md
Name: game_controller_nxn

Overview:
- Parametrised successor of the 3x3 tic-tac-toe game controller: N x N board, win on any complete row, column or main diagonal.
- Owns the board storage internally, so the board clears itself after reset with no external clear sequence.
- Accepts player moves over a write strobe and rejects illegal moves.
- Reports win/draw and drives the flat board bus to the display and win-check logic.

Parameters:
- BOARD_N, 3, board side length; legal range 3..8.
- ADDR_W, $clog2(BOARD_N*BOARD_N), cell address width.
- TIMEOUT_CYCLES, 1000, idle-turn limit; used only with the optional feature.

Ports:
- ph1  in  1  single system clock; rising edge active; no ph2 in this block.
- reset  in  1  asynchronous, active-high.
- isPlayer1Start  in  1  sampled at game start; 1 = player1 (X) moves first.
- newGame  in  1  one-cycle pulse; restarts from CLEAR in any state.
- playerWrite  in  1  one-cycle move strobe.
- playerInput  in  ADDR_W  cell index, row-major; cell 0 is upper-left.
- gBoard  out  2*BOARD_N*BOARD_N  cell i occupies bits [2i+1:2i]; EMPTY=00, X=10, O=11.
- gameIsDone  out  1  high in END.
- winner  out  2  00 none/draw, 10 X, 11 O; valid when gameIsDone is high.
- currentPlayer  out  1  0 = player1 (X), 1 = player2 (O).
- moveAccepted  out  1  one-cycle pulse.
- moveRejected  out  1  one-cycle pulse.
- moveCount  out  ADDR_W+1  number of placed pieces.

Behaviour:
- Reset is asynchronous; reset values:
  - state=CLEAR, clear counter=0, gBoard=0.
  - gameIsDone=0, winner=00, currentPlayer=0, moveAccepted=0, moveRejected=0, moveCount=0.
- State machine states: CLEAR, PLAYER1, PLAYER2, END.
- CLEAR:
  - Writes EMPTY to cell[cnt] each cycle for N*N cycles.
  - On the last cell, goes to PLAYER1 if isPlayer1Start=1, else PLAYER2.
  - playerWrite is ignored during CLEAR.
- PLAYER1 / PLAYER2, on playerWrite:
  - playerInput >= N*N, or target cell not EMPTY: moveRejected pulses the next cycle; board, state and moveCount are unchanged.
  - Otherwise the cell is written with X (PLAYER1) or O (PLAYER2) at the next edge, moveAccepted pulses the same cycle, moveCount increments, and the state toggles to the other player.
  - Latency strobe -> gBoard update: 1 cycle.
- Win check:
  - Combinational over the registered board: 2N+2 lines, each needing all N cells equal and non-EMPTY.
  - Evaluated the cycle after each accepted move.
  - Win: state goes to END, winner = the mover's code.
  - Else if moveCount == N*N: state goes to END, winner=00 (draw).
  - A win on the final move reports the win, not a draw.
- END: holds the board; gameIsDone=1; moves are ignored with no reject pulse.
- newGame:
  - Has priority over playerWrite in the same cycle.
  - Clears winner, gameIsDone and moveCount; enters CLEAR.
- currentPlayer mirrors the state in PLAYER1/PLAYER2 and holds its last value in CLEAR/END.
- A reset asserted mid-move aborts the move; the board returns to all-EMPTY.

Optional Feature:
- Macro: MOVE_TIMEOUT_EN.
- When defined:
  - A turn counter increments every cycle in PLAYER1/PLAYER2 and resets on any accepted move or state change.
  - When it reaches TIMEOUT_CYCLES, the turn passes to the other player with no board change.
  - Output timeoutPulse (1 bit) pulses for 1 cycle; reset value 0.
- When undefined: no counter, no timeoutPulse port; a player may wait indefinitely.

Test Plan:
- Reset, N=3 -> gBoard=0 for 9 CLEAR cycles; with isPlayer1Start=1, PLAYER1 is reached on cycle 10 and currentPlayer=0.
- Legal move sequence:
  - Write cell 0 -> gBoard[1:0]=10, moveAccepted=1, currentPlayer=1.
  - Write cell 4 -> gBoard[9:8]=11, moveCount=2.
- Illegal moves:
  - Write cell 4 again -> moveRejected=1, board and turn unchanged.
  - playerInput=9 -> moveRejected=1.
- X plays 0, 1, 2 around O moves -> gameIsDone=1, winner=10; a further playerWrite has no effect.
- Draw sequence X0 O1 X2 O4 X3 O5 X7 O6 X8 -> gameIsDone=1, winner=00, moveCount=9.
- Corner and restart cases:
  - N=4 anti-diagonal O win on cells 3, 6, 9, 12 -> winner=11.
  - newGame and playerWrite asserted in the same cycle -> CLEAR is entered and the board becomes all-EMPTY.
  - With MOVE_TIMEOUT_EN and TIMEOUT_CYCLES=20: idle for 20 cycles -> timeoutPulse=1 and the turn toggles.
